// File: rtl/pim_access_ctrl.sv
// rtl/pim_access_ctrl.sv - PIM macro access sequencer
// Single-outstanding request, range/alignment check, timed enable window, handshaked response.
module pim_access_ctrl #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] ADDR_BASE  = 32'h2000_0000,
    parameter logic [XLEN-1:0] ADDR_SIZE  = 32'h0000_1000,
    parameter int              RD_LATENCY = 3,
    parameter int              WR_LATENCY = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [XLEN-1:0] rsp_rdata_o,
    output logic            rsp_err_o,
    output logic [XLEN-1:0] pim_addr_o,
    output logic [XLEN-1:0] pim_wd_o,
    output logic            pim_we_o,
    output logic            pim_en_o,
    input  logic [XLEN-1:0] pim_rd_i
);

    localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    // Window bounds carried in XLEN+1 bits so BASE+SIZE cannot wrap.
    localparam logic [XLEN:0] WIN_LO = {1'b0, ADDR_BASE};
    localparam logic [XLEN:0] WIN_HI = {1'b0, ADDR_BASE} + {1'b0, ADDR_SIZE};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t          r_state,     w_state;
    logic [CW-1:0]   r_cnt,       w_cnt;
    logic            r_req_ready, w_req_ready;
    logic            r_rsp_valid, w_rsp_valid;
    logic [XLEN-1:0] r_rsp_rdata, w_rsp_rdata;
    logic            r_rsp_err,   w_rsp_err;
    logic [XLEN-1:0] r_pim_addr,  w_pim_addr;
    logic [XLEN-1:0] r_pim_wd,    w_pim_wd;
    logic            r_pim_we,    w_pim_we;
    logic            r_pim_en,    w_pim_en;

    logic [XLEN:0]   w_addr_ext;
    logic            w_legal;
    logic [XLEN-1:0] w_offset;

    assign w_addr_ext = {1'b0, req_addr_i};
    assign w_legal    = (w_addr_ext >= WIN_LO) && (w_addr_ext < WIN_HI) &&
                        (req_addr_i[1:0] == 2'b00);
    assign w_offset   = req_addr_i - ADDR_BASE;

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_req_ready = r_req_ready;
        w_rsp_valid = r_rsp_valid;
        w_rsp_rdata = r_rsp_rdata;
        w_rsp_err   = r_rsp_err;
        w_pim_addr  = r_pim_addr;
        w_pim_wd    = r_pim_wd;
        w_pim_we    = r_pim_we;
        w_pim_en    = r_pim_en;
        case (r_state)
            IDLE: begin
                w_req_ready = 1'b1;
                if (req_valid_i && r_req_ready) begin
                    w_req_ready = 1'b0;
                    if (w_legal) begin
                        w_pim_addr = w_offset;
                        if (req_we_i) begin
                            w_pim_wd = req_wdata_i;
                        end
                        w_pim_we = req_we_i;
                        w_pim_en = 1'b1;
                        w_cnt    = req_we_i ? CW'(WR_LATENCY - 1) : CW'(RD_LATENCY - 1);
                        w_state  = ACCESS;
                    end else begin
                        w_rsp_valid = 1'b1;
                        w_rsp_err   = 1'b1;
                        w_rsp_rdata = '0;
                        w_state     = RESP;
                    end
                end
            end
            ACCESS: begin
                w_req_ready = 1'b0;
                if (r_cnt == '0) begin
                    // Capture edge: the only cycle pim_rd_i is looked at.
                    w_rsp_rdata = r_pim_we ? '0 : pim_rd_i;
                    w_rsp_err   = 1'b0;
                    w_rsp_valid = 1'b1;
                    w_pim_en    = 1'b0;
                    w_pim_we    = 1'b0;
                    w_state     = RESP;
                end else begin
                    w_cnt = r_cnt - CW'(1);
                end
            end
            RESP: begin
                w_req_ready = 1'b0;
                w_rsp_valid = 1'b1;
                if (rsp_ready_i) begin
                    w_rsp_valid = 1'b0;
                    w_req_ready = 1'b1;
                    w_state     = IDLE;
                end
            end
            default: begin
                w_state     = IDLE;
                w_req_ready = 1'b1;
                w_rsp_valid = 1'b0;
                w_pim_en    = 1'b0;
                w_pim_we    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_pim_addr  <= '0;
            r_pim_wd    <= '0;
            r_pim_we    <= 1'b0;
            r_pim_en    <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_req_ready <= w_req_ready;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_rdata <= w_rsp_rdata;
            r_rsp_err   <= w_rsp_err;
            r_pim_addr  <= w_pim_addr;
            r_pim_wd    <= w_pim_wd;
            r_pim_we    <= w_pim_we;
            r_pim_en    <= w_pim_en;
        end
    end

    assign req_ready_o = r_req_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_err_o   = r_rsp_err;
    assign pim_addr_o  = r_pim_addr;
    assign pim_wd_o    = r_pim_wd;
    assign pim_we_o    = r_pim_we;
    assign pim_en_o    = r_pim_en;

endmodule
